// File: rtl/eif_pkg.sv
// Shared FSM encoding and default neuron constants for the EIF scheduler.
package eif_pkg;

  localparam int EIF_N_NEUR     = 4;
  localparam int EIF_VT         = 150;
  localparam int EIF_VPEAK      = 240;
  localparam int EIF_VRESET     = 20;
  localparam int EIF_LEAK_SHIFT = 3;
  localparam int EIF_IDX_W      = $clog2(EIF_N_NEUR);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_WRITE,
    ST_DONE
  } eif_state_t;

endpackage

// File: rtl/eif_step.sv
// One exponential integrate-and-fire update: leak, input current, exponential
// term above the knee, saturation and spike/reset decision.
module eif_step
  import eif_pkg::*;
#(
  parameter int VT         = EIF_VT,
  parameter int VPEAK      = EIF_VPEAK,
  parameter int VRESET     = EIF_VRESET,
  parameter int LEAK_SHIFT = EIF_LEAK_SHIFT
) (
  input  logic [7:0] v,
  input  logic [7:0] i_in,
  output logic [7:0] v_next,
  output logic       spike
);

  logic [9:0] v_ext;
  logic [9:0] leak;
  logic [9:0] exp_term;
  logic [9:0] sum;
  logic [7:0] sat;

  // 10 bits hold the worst case 255 - 31 + 255 + 210 without wrapping
  always_comb begin
    v_ext    = {2'b00, v};
    leak     = v_ext >> LEAK_SHIFT;
    exp_term = (v_ext >= 10'(VT)) ? ((v_ext - 10'(VT)) << 1) : 10'd0;
    sum      = v_ext - leak + {2'b00, i_in} + exp_term;
    sat      = (sum > 10'd255) ? 8'hFF : sum[7:0];
    spike    = (sat >= 8'(VPEAK));
    v_next   = spike ? 8'(VRESET) : sat;
  end

endmodule

// File: rtl/eif_scheduler.sv
// Time-multiplexed EIF neuron array: one shared eif_step datapath sweeps all
// virtual neurons per tick and emits spikes over a valid/ready channel.
module eif_scheduler
  import eif_pkg::*;
#(
  parameter int N_NEUR     = EIF_N_NEUR,
  parameter int VT         = EIF_VT,
  parameter int VPEAK      = EIF_VPEAK,
  parameter int VRESET     = EIF_VRESET,
  parameter int LEAK_SHIFT = EIF_LEAK_SHIFT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 cfg_we,
  input  logic [EIF_IDX_W-1:0] cfg_addr,
  input  logic [7:0]           cfg_data,
  output logic                 spike_valid,
  output logic [EIF_IDX_W-1:0] spike_id,
  input  logic                 spike_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun,
  output logic [7:0]           state_out
);

  localparam int IDX_W = EIF_IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEUR - 1);

  eif_state_t       state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [7:0]       v_next_reg;
  logic             spike_reg;

  logic [7:0] v_mem    [N_NEUR];
  logic [7:0] i_in_mem [N_NEUR];
  logic [7:0] step_v_next;
  logic       step_spike;
  logic       write_go;

  // A spiking neuron may only leave WRITE once the spike channel is free
  assign write_go = (state_reg == ST_WRITE) &&
                    !(spike_reg && spike_valid && !spike_ready);
  assign busy     = (state_reg != ST_IDLE);
  assign done     = (state_reg == ST_DONE);

  for (genvar gi = 0; gi < N_NEUR; gi++) begin : g_neuron
    logic [7:0] v_q;
    logic [7:0] i_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        i_q <= '0;
      end else begin
        if (write_go && idx_reg == IDX_W'(gi)) v_q <= v_next_reg;
        if (cfg_we && cfg_addr == IDX_W'(gi))  i_q <= cfg_data;
      end
    end

    assign v_mem[gi]    = v_q;
    assign i_in_mem[gi] = i_q;
  end

  eif_step #(
    .VT         (VT),
    .VPEAK      (VPEAK),
    .VRESET     (VRESET),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_step (
    .v      (v_mem[idx_reg]),
    .i_in   (i_in_mem[idx_reg]),
    .v_next (step_v_next),
    .spike  (step_spike)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= '0;
      v_next_reg  <= '0;
      spike_reg   <= 1'b0;
      spike_valid <= 1'b0;
      spike_id    <= '0;
      state_out   <= '0;
      overrun     <= 1'b0;
    end else begin
      if (tick && state_reg != ST_IDLE) overrun <= 1'b1;
      // A spike raised in WRITE below overrides this clear
      if (spike_valid && spike_ready) spike_valid <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (tick) begin
            idx_reg   <= '0;
            state_reg <= ST_CALC;
          end
        end
        ST_CALC: begin
          v_next_reg <= step_v_next;
          spike_reg  <= step_spike;
          state_reg  <= ST_WRITE;
        end
        ST_WRITE: begin
          if (write_go) begin
            state_out <= v_next_reg;
            if (spike_reg) begin
              spike_valid <= 1'b1;
              spike_id    <= idx_reg;
            end
            if (idx_reg == LAST_IDX) begin
              state_reg <= ST_DONE;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= ST_CALC;
            end
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eif_scheduler.sv
// Directed bench for eif_scheduler with a per-sweep arithmetic model and a
// per-cycle compare process on the spike channel and sweep results.
module tb_eif_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_data = 8'd0;
  logic       spike_ready = 1'b0;
  logic       spike_valid;
  logic [1:0] spike_id;
  logic       busy;
  logic       done;
  logic       overrun;
  logic [7:0] state_out;

  int n_checks = 0;
  int n_fail   = 0;

  int m_v [4];
  int m_i [4];
  int exp_spikes [$];
  int m_last     = 0;
  int m_overrun  = 0;
  int n_sweeps   = 0;
  int n_done     = 0;
  int n_acc      = 0;
  bit pend_hold  = 1'b0;
  int held_id    = 0;
  bit prev_done  = 1'b0;

  always #5 clk = ~clk;

  eif_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .spike_valid (spike_valid),
    .spike_id    (spike_id),
    .spike_ready (spike_ready),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .state_out   (state_out)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Whole-sweep model: every neuron updated in index order from the current set
  task automatic model_sweep();
    int e;
    int r;
    for (int k = 0; k < 4; k++) begin
      e = (m_v[k] >= 150) ? 2 * (m_v[k] - 150) : 0;
      r = m_v[k] - m_v[k] / 8 + m_i[k] + e;
      if (r > 255) r = 255;
      if (r >= 240) begin
        m_v[k] = 20;
        exp_spikes.push_back(k);
      end else begin
        m_v[k] = r;
      end
    end
    m_last = m_v[3];
    n_sweeps++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_v[k] = 0;
      m_i[k] = 0;
    end
    exp_spikes.delete();
    m_overrun = 0;
    m_last = 0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = 2'(a);
    cfg_data = 8'(d);
    wait_clk(1);
    cfg_we = 1'b0;
    m_i[a] = d;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    wait_clk(1);
    tick = 1'b0;
  endtask

  task automatic wait_done(inout int cyc);
    while (!done && cyc < 300) begin
      wait_clk(1);
      cyc++;
    end
  endtask

  task automatic do_tick(input int exp_len);
    int cyc = 0;
    model_sweep();
    pulse_tick();
    wait_done(cyc);
    $display("sweep %0d: length %0d, state_out %0d", n_sweeps, cyc, state_out);
    check("sweep_len", cyc, exp_len);
    wait_clk(1);
    check("busy_after_done", busy, 0);
  endtask

  // Compare process: spike channel protocol, spike order and per-sweep results
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_hold = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (pend_hold) begin
        check("spike_hold_valid", spike_valid, 1);
        check("spike_hold_id", spike_id, held_id);
      end
      if (done) begin
        n_done++;
        check("done_one_cycle", prev_done, 0);
        check("state_out", state_out, m_last);
        for (int k = 0; k < 4; k++)
          check($sformatf("v%0d", k), dut.v_mem[k], m_v[k]);
        check("overrun", overrun, m_overrun);
        check("spike_valid_at_done", spike_valid, int'(exp_spikes.size() != 0));
      end
      if (spike_valid && spike_ready) begin
        n_acc++;
        if (exp_spikes.size() != 0) begin
          held_id = exp_spikes.pop_front();
          check("spike_id", spike_id, held_id);
        end else begin
          check("spike_id_unexpected", spike_id, -1);
        end
        $display("spike accepted: id %0d", spike_id);
      end
      pend_hold = spike_valid && !spike_ready;
      held_id   = spike_id;
      prev_done = done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit [7] = '{40, 75, 106, 133, 157, 192, 20};
    int base;
    int cyc;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_spike_valid", spike_valid, 0);
    check("rst_spike_id", spike_id, 0);
    check("rst_state_out", state_out, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    wait_clk(1);

    // All currents zero: quiet sweep of exactly 8 cycles
    do_tick(8);

    // Neuron 0 driven at 40: climbs into the exponential region then fires
    spike_ready = 1'b1;
    cfg(0, 40);
    base = n_acc;
    for (int t = 0; t < 7; t++) begin
      do_tick(8);
      check("v0_literal", m_v[0], lit[t]);
    end
    check("v0_spike_count", n_acc - base, 1);

    // Back-pressure: pending spike from neuron 2 stalls the next sweep
    cfg(0, 0);
    cfg(2, 255);
    spike_ready = 1'b0;
    do_tick(8);
    check("pending_valid", spike_valid, 1);
    check("pending_id", spike_id, 2);
    base = n_done;
    model_sweep();
    pulse_tick();
    wait_clk(12);
    check("stall_busy", busy, 1);
    check("stall_no_done", n_done, base);
    check("stall_valid", spike_valid, 1);
    check("stall_id", spike_id, 2);
    spike_ready = 1'b1;
    cyc = 0;
    wait_done(cyc);
    check("stall_done", done, 1);
    wait_clk(1);
    check("spikes_drained", exp_spikes.size(), 0);

    // Ticks mid-sweep and in DONE: overrun, no extra sweep, unchanged length
    cfg(3, 30);
    model_sweep();
    pulse_tick();
    cyc = 0;
    wait_clk(3);
    cyc += 3;
    m_overrun = 1;
    pulse_tick();
    cyc++;
    wait_done(cyc);
    check("overrun_sweep_len", cyc, 8);
    tick = 1'b1;
    wait_clk(1);
    tick = 1'b0;
    check("done_tick_idle", busy, 0);
    check("done_tick_overrun", overrun, 1);
    wait_clk(10);
    check("no_extra_sweep_busy", busy, 0);
    check("no_extra_sweep_count", n_done, n_sweeps);

    // Asynchronous reset during CALC of neuron 1
    pulse_tick();
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_spike_valid", spike_valid, 0);
    check("arst_spike_id", spike_id, 0);
    check("arst_state_out", state_out, 0);
    check("arst_overrun", overrun, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("arst_v%0d", k), dut.v_mem[k], 0);
      check($sformatf("arst_i%0d", k), dut.i_in_mem[k], 0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cfg(0, 40);
    do_tick(8);
    check("restart_v0", m_v[0], 40);

    // cfg write to neuron 1 during its own CALC applies from the next sweep
    cfg(1, 10);
    do_tick(8);
    check("v1_before", m_v[1], 10);
    model_sweep();
    pulse_tick();
    wait_clk(2);
    cfg_we   = 1'b1;
    cfg_addr = 2'd1;
    cfg_data = 8'd100;
    wait_clk(1);
    cfg_we = 1'b0;
    m_i[1] = 100;
    cyc = 3;
    wait_done(cyc);
    check("cfg_calc_sweep_len", cyc, 8);
    check("v1_old_current", m_v[1], 19);
    wait_clk(1);
    do_tick(8);
    check("v1_new_current", m_v[1], 117);

    check("total_sweeps", n_done, n_sweeps);
    check("final_spikes_drained", exp_spikes.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eif_scheduler.md
EIF_SCHEDULER -- requirements
Module: eif_scheduler

Interface
REQ-001 SHALL provide parameters: N_NEUR=4 (virtual neurons), VT=150 (exponential knee), VPEAK=240 (spike level), VRESET=20 (post-spike value), LEAK_SHIFT=3.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-004 SHALL have port tick, input, 1 bit: starts one update sweep over all neurons.
REQ-005 SHALL have ports cfg_we (input, 1 bit), cfg_addr (input, 2 bits) and cfg_data (input, 8 bits): write the input current of neuron cfg_addr.
REQ-006 SHALL have ports spike_valid (output, 1 bit), spike_id (output, 2 bits) and spike_ready (input, 1 bit): spike event valid/ready handshake.
REQ-007 SHALL have ports busy (output, 1 bit), done (output, 1 bit, one-cycle pulse at sweep end) and overrun (output, 1 bit, sticky).
REQ-008 SHALL have port state_out, output, 8 bits: membrane value written back in the most recent WRITE cycle.

Function
REQ-009 SHALL hold per neuron an 8-bit membrane register v[i] and an 8-bit current register i_in[i].
REQ-010 SHALL implement FSM states IDLE, CALC, WRITE and DONE.
REQ-011 IDLE SHALL go to CALC with idx=0 when tick=1; busy=1 in every state except IDLE.
REQ-012 CALC (1 cycle) SHALL sample v[idx] and i_in[idx] and register the next value and the spike flag.
REQ-013 The next value SHALL be computed in 10-bit unsigned arithmetic as v - (v>>LEAK_SHIFT) + i_in + E, where E = 2*(v-VT) if v>=VT, else 0; the result SHALL saturate at 255.
REQ-014 When the saturated result is >= VPEAK, the scheduler SHALL flag a spike and write back VRESET; otherwise it SHALL write back the saturated result.
REQ-015 WRITE SHALL write back v[idx] and update state_out; on a spike it SHALL assert spike_valid with spike_id=idx.
REQ-016 WRITE SHALL NOT assert a new spike while spike_valid=1 and spike_ready=0; the FSM SHALL stall in WRITE until the pending event is accepted.
REQ-017 WRITE SHALL go to CALC with idx+1, or to DONE after idx=N_NEUR-1, so an unstalled sweep takes 2*N_NEUR cycles.
REQ-018 DONE SHALL pulse done=1 for exactly one cycle, then return to IDLE.
REQ-019 spike_valid/spike_id SHALL stay stable until spike_valid&&spike_ready, and spike_valid SHALL drop on the cycle after acceptance unless a new spike is raised in that same cycle.
REQ-020 A tick arriving while busy=1 SHALL be ignored and SHALL set overrun=1; overrun SHALL clear only on reset.
REQ-021 cfg writes SHALL take effect at any time; a write to a neuron in the same cycle as its CALC SHALL apply from the next sweep, because CALC samples the old value.
REQ-022 A tick in the DONE cycle SHALL count as overrun and SHALL NOT start a sweep.

Reset
REQ-023 Asserting rst_n=0 SHALL, asynchronously and at any point mid-sweep, set: FSM to IDLE, idx=0, all v[i]=0, all i_in[i]=0, spike_valid=0, spike_id=0, busy=0, done=0, overrun=0, state_out=0.
REQ-024 The first tick after rst_n rises SHALL be honoured.

Structure
REQ-025 The FSM state enum, the default N_NEUR, VT, VPEAK, VRESET and LEAK_SHIFT, and the neuron index width SHALL live in shared package eif_pkg.
REQ-026 The update arithmetic of REQ-013 and REQ-014 SHALL be a combinational sub-module eif_step (inputs v and i_in; outputs v_next and spike), reusable by the single-neuron datapath.

Verification
REQ-027 Reset then tick with all currents 0 -> no spikes, done after exactly 8 cycles, state_out=0.
REQ-028 i_in[0]=40, spike_ready=1, repeated ticks -> v[0] follows 40, 75, 106, 133, 157, 192; the 7th tick gives a spike with spike_id=0 and v[0]=20.
REQ-029 i_in[2]=255, spike_ready=0 -> spike_valid held with spike_id=2 and the FSM stalled in WRITE; raising spike_ready -> the sweep completes and done pulses.
REQ-030 tick reasserted mid-sweep and in the DONE cycle -> overrun=1, no extra sweep, sweep length unchanged.
REQ-031 rst_n pulled low during CALC of neuron 1 -> all outputs and registers at reset values immediately; the next tick restarts at idx=0.
REQ-032 cfg write to neuron 1 in its CALC cycle -> the current sweep uses the old current and the next sweep uses the new one.
